// File: rtl/dma_stream_fifo.sv
// Per-stream byte FIFO for the DMA core: buffers source bytes, drives the arbiter
// request/level inputs and drains bytes while the stream is selected; flushes on disable.
module dma_stream_fifo #(
  parameter int size_exp = 5
) (
  input  logic                i_clk,
  input  logic                i_nreset,
  input  logic                i_en_stream,
  input  logic [1:0]          i_thr,
  input  logic                i_wr_valid,
  input  logic [1:0]          i_wr_size,
  input  logic [31:0]         i_wr_data,
  output logic                o_wr_ready,
  output logic                o_wr_err,
  input  logic                i_rd_valid,
  input  logic [1:0]          i_rd_size,
  output logic [31:0]         o_rd_data,
  output logic                o_rd_err,
  output logic                o_request,
  output logic [size_exp:0]   o_left_bytes,
  output logic                o_flushing
);

  localparam int DEPTH = 2 ** size_exp;
  localparam int LW    = size_exp + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  state_e               state_q, state_d;
  logic [size_exp-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 req_q, req_d, wr_err_q, rd_err_q;
  logic [7:0]           mem_q [DEPTH];

  logic [2:0]           wr_bytes_s, rd_bytes_s;
  logic [LW-1:0]        space_s, thr_bytes_s;
  logic                 wr_ready_s, push_s, pop_s;
  logic [31:0]          rd_data_s;

  // Access qualification and next level; ready uses the registered level only
  always_comb begin
    wr_bytes_s  = size_bytes(i_wr_size);
    rd_bytes_s  = size_bytes(i_rd_size);
    space_s     = LW'(DEPTH) - level_q;
    wr_ready_s  = (state_q == FILL) && (i_wr_size != 2'b11) && (space_s >= LW'(wr_bytes_s));
    push_s      = i_wr_valid && wr_ready_s;
    pop_s       = i_rd_valid && (state_q != IDLE) && (i_rd_size != 2'b11) &&
                  (LW'(rd_bytes_s) <= level_q);
    level_d     = level_q + (push_s ? LW'(wr_bytes_s) : {LW{1'b0}})
                          - (pop_s ? LW'(rd_bytes_s) : {LW{1'b0}});
    thr_bytes_s = LW'({1'b0, i_thr} + 3'd1) << (size_exp - 2);
  end

  // Next state, pointers and request; leaving for IDLE always clears the pointers
  always_comb begin
    state_d = state_q;
    wptr_d  = push_s ? wptr_q + size_exp'(wr_bytes_s) : wptr_q;
    rptr_d  = pop_s ? rptr_q + size_exp'(rd_bytes_s) : rptr_q;
    case (state_q)
      IDLE: begin
        state_d = i_en_stream ? FILL : IDLE;
        wptr_d  = {size_exp{1'b0}};
        rptr_d  = {size_exp{1'b0}};
      end
      FILL: begin
        state_d = i_en_stream ? FILL : ((level_d == {LW{1'b0}}) ? IDLE : FLUSH);
      end
      FLUSH: begin
        state_d = (level_d == {LW{1'b0}}) ? IDLE : FLUSH;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    wptr_d = (state_d == IDLE) ? {size_exp{1'b0}} : wptr_d;
    rptr_d = (state_d == IDLE) ? {size_exp{1'b0}} : rptr_d;
    case (state_d)
      FILL:    req_d = (level_d >= thr_bytes_s);
      FLUSH:   req_d = (level_d != {LW{1'b0}});
      default: req_d = 1'b0;
    endcase
  end

  // Control registers and registered status/error outputs
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state_q  <= IDLE;
      wptr_q   <= {size_exp{1'b0}};
      rptr_q   <= {size_exp{1'b0}};
      level_q  <= {LW{1'b0}};
      req_q    <= 1'b0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      req_q    <= req_d;
      wr_err_q <= i_wr_valid && (state_q == FILL) && (i_wr_size == 2'b11);
      rd_err_q <= i_rd_valid && !pop_s;
    end
  end

  // Byte storage; each lane lands at wptr+k so a push may straddle the wrap point
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (push_s && (3'(k) < wr_bytes_s)) mem_q[wptr_q + size_exp'(k)] <= i_wr_data[8*k +: 8];
      end
    end
  end

  // Head bytes for the requested pop size; lanes past the size read zero
  always_comb begin
    rd_data_s = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      rd_data_s[8*k +: 8] = (3'(k) < rd_bytes_s) ? mem_q[rptr_q + size_exp'(k)] : 8'h00;
    end
  end

  assign o_wr_ready   = wr_ready_s;
  assign o_wr_err     = wr_err_q;
  assign o_rd_data    = rd_data_s;
  assign o_rd_err     = rd_err_q;
  assign o_request    = req_q;
  assign o_left_bytes = level_q;
  assign o_flushing   = (state_q == FLUSH);

endmodule

// File: tb/tb_dma_stream_fifo.sv
// Directed bench for dma_stream_fifo (size_exp=5): threshold, wrap, full/ready,
// flush, error pulses and asynchronous reset, checked with immediate assertions.
module tb_dma_stream_fifo;

  logic        i_clk = 1'b0;
  logic        i_nreset, i_en_stream, i_wr_valid, i_rd_valid;
  logic [1:0]  i_thr, i_wr_size, i_rd_size;
  logic [31:0] i_wr_data;
  logic        o_wr_ready, o_wr_err, o_rd_err, o_request, o_flushing;
  logic [31:0] o_rd_data;
  logic [5:0]  o_left_bytes;
  int          checks = 0;
  int          failures = 0;

  dma_stream_fifo #(.size_exp(5)) dut (
    .i_clk(i_clk), .i_nreset(i_nreset), .i_en_stream(i_en_stream), .i_thr(i_thr),
    .i_wr_valid(i_wr_valid), .i_wr_size(i_wr_size), .i_wr_data(i_wr_data),
    .o_wr_ready(o_wr_ready), .o_wr_err(o_wr_err),
    .i_rd_valid(i_rd_valid), .i_rd_size(i_rd_size), .o_rd_data(o_rd_data),
    .o_rd_err(o_rd_err), .o_request(o_request), .o_left_bytes(o_left_bytes),
    .o_flushing(o_flushing)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [1:0] sz, input logic [31:0] d);
    i_wr_valid = 1'b1; i_wr_size = sz; i_wr_data = d;
    tick();
    i_wr_valid = 1'b0;
  endtask

  task automatic pop(input logic [1:0] sz);
    i_rd_valid = 1'b1; i_rd_size = sz;
    tick();
    i_rd_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [1:0] sz, input logic [31:0] exp);
    i_rd_valid = 1'b1; i_rd_size = sz;
    #1;
    chk(tag, o_rd_data, exp);
    tick();
    i_rd_valid = 1'b0;
  endtask

  initial begin
    i_nreset = 1'b0; i_en_stream = 1'b0; i_thr = 2'b01;
    i_wr_valid = 1'b0; i_wr_size = 2'b10; i_wr_data = 32'h0;
    i_rd_valid = 1'b0; i_rd_size = 2'b10;
    #12;
    chk("rst_level", 32'(o_left_bytes), 32'd0);
    chk("rst_request", 32'(o_request), 32'd0);
    chk("rst_ready", 32'(o_wr_ready), 32'd0);
    chk("rst_rd_data", o_rd_data, 32'h0);
    chk("rst_flushing", 32'(o_flushing), 32'd0);
    tick();
    i_nreset = 1'b1; i_en_stream = 1'b1;
    tick();
    chk("fill_ready", 32'(o_wr_ready), 32'd1);

    // Threshold 1/2 of 32 bytes
    push(2'b10, 32'h03020100);
    push(2'b10, 32'h07060504);
    push(2'b10, 32'h0B0A0908);
    chk("thr_req_12", 32'(o_request), 32'd0);
    chk("thr_level_12", 32'(o_left_bytes), 32'd12);
    push(2'b10, 32'h0F0E0D0C);
    chk("thr_req_16", 32'(o_request), 32'd1);
    chk("thr_level_16", 32'(o_left_bytes), 32'd16);
    pop_chk("thr_pop_data", 2'b10, 32'h03020100);
    chk("thr_req_after_pop", 32'(o_request), 32'd0);

    // Asynchronous reset mid-FILL at level 12
    i_nreset = 1'b0;
    #1;
    chk("arst_level", 32'(o_left_bytes), 32'd0);
    chk("arst_request", 32'(o_request), 32'd0);
    chk("arst_ready", 32'(o_wr_ready), 32'd0);
    tick();
    i_nreset = 1'b1;
    tick();

    // Wrap: fill 30 bytes with values 0..29
    for (int i = 0; i < 7; i++) push(2'b10, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
    push(2'b01, 32'h00001D1C);
    chk("wrap_level_30", 32'(o_left_bytes), 32'd30);
    i_wr_size = 2'b10; #1;
    chk("full_ready_4B", 32'(o_wr_ready), 32'd0);
    i_wr_size = 2'b01; #1;
    chk("full_ready_2B", 32'(o_wr_ready), 32'd1);
    i_wr_size = 2'b10; i_rd_valid = 1'b1; i_rd_size = 2'b01; #1;
    chk("full_ready_concurrent_pop", 32'(o_wr_ready), 32'd0);
    chk("pop2_data", o_rd_data, 32'h00000100);
    tick();
    i_rd_valid = 1'b0;
    chk("wrap_level_28", 32'(o_left_bytes), 32'd28);
    for (int j = 0; j < 6; j++)
      pop_chk("wrap_pop4", 2'b10, {8'(4*j+5), 8'(4*j+4), 8'(4*j+3), 8'(4*j+2)});
    pop_chk("wrap_pop_1a1b", 2'b01, 32'h00001B1A);
    chk("wrap_level_2", 32'(o_left_bytes), 32'd2);
    push(2'b10, 32'hDDCCBBAA);
    chk("wrap_level_6", 32'(o_left_bytes), 32'd6);
    pop_chk("wrap_pop_1d1c", 2'b01, 32'h00001D1C);
    pop_chk("wrap_word", 2'b10, 32'hDDCCBBAA);
    chk("wrap_level_0", 32'(o_left_bytes), 32'd0);
    chk("wrap_req_0", 32'(o_request), 32'd0);

    // Errors
    push(2'b01, 32'h00002211);
    push(2'b00, 32'h00000033);
    chk("err_level_3", 32'(o_left_bytes), 32'd3);
    pop(2'b10);
    chk("rd_err_pulse", 32'(o_rd_err), 32'd1);
    chk("rd_err_level", 32'(o_left_bytes), 32'd3);
    tick();
    chk("rd_err_clear", 32'(o_rd_err), 32'd0);
    pop(2'b11);
    chk("rd_err_size11", 32'(o_rd_err), 32'd1);
    push(2'b11, 32'hFFFFFFFF);
    chk("wr_err_pulse", 32'(o_wr_err), 32'd1);
    chk("wr_err_level", 32'(o_left_bytes), 32'd3);
    tick();
    chk("wr_err_clear", 32'(o_wr_err), 32'd0);

    // Flush from level 6, re-enable has no effect until IDLE
    push(2'b01, 32'h00005544);
    push(2'b00, 32'h00000066);
    i_en_stream = 1'b0;
    tick();
    chk("flush_state", 32'(o_flushing), 32'd1);
    chk("flush_req", 32'(o_request), 32'd1);
    chk("flush_level", 32'(o_left_bytes), 32'd6);
    i_wr_valid = 1'b1; i_wr_size = 2'b00; i_wr_data = 32'h000000EE; #1;
    chk("flush_ready", 32'(o_wr_ready), 32'd0);
    i_en_stream = 1'b1;
    tick();
    i_wr_valid = 1'b0;
    chk("flush_push_refused", 32'(o_left_bytes), 32'd6);
    pop_chk("flush_pop4", 2'b10, 32'h44332211);
    chk("flush_still", 32'(o_flushing), 32'd1);
    chk("flush_req_l2", 32'(o_request), 32'd1);
    pop_chk("flush_pop2", 2'b01, 32'h00006655);
    chk("flush_done", 32'(o_flushing), 32'd0);
    chk("flush_req_0", 32'(o_request), 32'd0);
    chk("flush_level_0", 32'(o_left_bytes), 32'd0);
    i_wr_size = 2'b00; #1;
    chk("idle_ready", 32'(o_wr_ready), 32'd0);
    tick();
    chk("refill_ready", 32'(o_wr_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
